// File: rtl/sig_pipe_stage.sv
// Elastic valid/ready pipeline for significand lanes of the FP MAC datapath.
// Empty stages fill even while the output stalls; flush drops all in-flight operands.
module sig_pipe_stage #(
    parameter int WIDTH = 11,
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_sig,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_sig,
    output logic [3:0]             occupancy
);
    localparam int SW = LANES * WIDTH;

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] ready;
    logic [SW-1:0]    d_q [DEPTH];
    logic [SW-1:0]    d_d [DEPTH];
    logic [3:0]       occ_q, occ_d;

    // A stage can load when some stage at or after it is empty or the output drains.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        ready     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tail_full = tail_full & v_q[i];
            ready[i]  = out_ready | ~tail_full;
        end
    end

    always_comb begin : next_state
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        v_d = v_q;
        d_d = d_q;
        if (ready[0]) begin
            v_d[0] = in_valid;
            if (in_valid) d_d[0] = in_sig;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (ready[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) d_d[i] = d_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
            d_d = d_q;
        end
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + 4'(v_d[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            occ_q <= '0;
            // NOTE: the data array is reset too, so no stale operand is visible on out_sig after reset.
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = ready[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_sig   = d_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
